// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling timing and majority-vote stage of the UART
// receiver. Produces the edge/bit counters consumed by the Rx FSM and a
// 3-sample majority-voted bit with a one-cycle update strobe.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx_in.
module uart_rx_sampler #(
    parameter int EDGE_W = 6,
    parameter int BIT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_in,
    input  logic [EDGE_W-1:0] prescale,
    input  logic              par_en,
    input  logic              edge_bit_counter_en,
    input  logic              data_sample_en,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sampled_bit,
    output logic              sample_valid
);

    logic [EDGE_W-1:0] half;
    logic [EDGE_W-1:0] win_lo;
    logic [EDGE_W-1:0] win_mid;
    logic [EDGE_W-1:0] edge_last;
    logic [BIT_W-1:0]  bit_last;
    logic              line;
    logic              sample_act;
    logic              s0;
    logic              s1;
    logic              win_ok;
    logic              vote;

    assign half      = prescale >> 1;
    assign win_lo    = half - EDGE_W'(2);
    assign win_mid   = half - EDGE_W'(1);
    assign edge_last = prescale - EDGE_W'(1);
    assign bit_last  = par_en ? BIT_W'(10) : BIT_W'(9);
    assign sample_act = data_sample_en && edge_bit_counter_en;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_in};
        end
    end

    assign line = sync[1];
`else
    assign line = rx_in;
`endif

    // Third sample is taken straight from the line so the vote lands on the
    // edge closing the edge_cnt == H cycle.
    assign vote = (s0 & s1) | (s0 & line) | (s1 & line);

    // Edge and bit counters; bit_cnt wraps at the stop bit with no dead cycle.
    always_ff @(posedge CLK) begin
        if (RST || !edge_bit_counter_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == edge_last) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == bit_last) ? '0 : bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end

    // Sample capture and vote; win_ok drops on any inactive cycle so a window
    // interrupted by data_sample_en never produces an update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            win_ok       <= 1'b0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!sample_act) begin
                win_ok <= 1'b0;
            end else if (edge_cnt == win_lo) begin
                s0     <= line;
                win_ok <= 1'b1;
            end else if (edge_cnt == win_mid) begin
                s1 <= line;
            end else if (edge_cnt == half) begin
                win_ok <= 1'b0;
                if (win_ok) begin
                    sampled_bit  <= vote;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Upstream timing and sampling stage of the UART receiver. Generates the edge and bit counters that the Rx FSM consumes.
- Oversamples rx_in and produces a majority-voted sampled_bit that the start, parity and stop checkers and the deserializer read.
- The Rx FSM drives its enables. The sampled_bit output is guaranteed stable on the cycle where edge_cnt == prescale/2 + 1, which is the FSM's check strobe.

Parameters:
- EDGE_W, 6, width of prescale and edge_cnt.
- BIT_W, 4, width of bit_cnt.

Ports:
- CLK  input  1  clock; single clock domain.
- RST  input  1  reset, synchronous, active-high.
- rx_in  input  1  serial line; idles high.
- prescale  input  EDGE_W  oversampling ratio. Legal values: 8, 16, 32. Must be stable while edge_bit_counter_en=1.
- par_en  input  1  parity bit present in the frame; must be stable during a frame.
- edge_bit_counter_en  input  1  from FSM; run the counters.
- data_sample_en  input  1  from FSM; enable sample capture.
- edge_cnt  output  EDGE_W  oversample index within the current bit.
- bit_cnt  output  BIT_W  bit index within the frame.
- sampled_bit  output  1  majority-voted bit value.
- sample_valid  output  1  one-cycle pulse; sampled_bit was updated this cycle.

Behaviour:
- Reset: when RST=1 at a CLK edge, edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0, and the sample registers are set to 3'b111. Reset mid-frame aborts immediately.
- Notation: P = prescale, H = P/2, LAST = par_en ? 10 : 9 (frame bits minus one).
- Counters when edge_bit_counter_en=0: edge_cnt and bit_cnt load 0 on the next edge.
- Counters when edge_bit_counter_en=1:
  - if edge_cnt == P-1: edge_cnt <= 0, and bit_cnt <= (bit_cnt == LAST) ? 0 : bit_cnt+1.
  - otherwise: edge_cnt <= edge_cnt+1 and bit_cnt holds.
- Resulting bit_cnt timing: reaches 1 after the start bit and 9 after the 8 data bits. Reaches 10 after parity when par_en=1. Wraps to 0 at the end of the stop bit, which is the FSM's STOP exit condition.
- Back-to-back frames: the counters keep running through the wrap with no dead cycle.
- Counter arithmetic is unsigned, width EDGE_W/BIT_W; no saturation.
- Sampling is active only when data_sample_en=1 and edge_bit_counter_en=1:
  - capture s0 at edge_cnt == H-2, s1 at edge_cnt == H-1, s2 at edge_cnt == H.
  - on the edge that ends the edge_cnt == H cycle: sampled_bit <= majority(s0, s1, current sample), and sample_valid <= 1 for exactly one cycle.
  - result: sampled_bit is new and stable while edge_cnt == H+1, and sample_valid is high in that same cycle.
- sampled_bit holds its value between updates and while sampling is disabled.
- If data_sample_en drops mid-bit, no update occurs for that bit and the partial s0/s1 values are discarded at the next window.
- Illegal prescale values (<8, odd, or >32) are unsupported, with no defined output. Changing prescale mid-frame is undefined.
- No combinational path from rx_in to any output. All outputs are registered.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx_in passes through a 2-flop synchronizer, reset to 1, before the sample logic. Sample points stay at edge_cnt H-2..H, but the sampled line lags the pin by 2 cycles. The sample window therefore sits 2 oversample ticks later in the bit; this is acceptable for P >= 8.
- Undefined: rx_in is sampled directly and must already be synchronous to CLK. The rest of the behaviour is identical.

Test Plan:
- Reset values:
  - stimulus: assert RST with the counters running at edge_cnt=5, bit_cnt=3.
  - required: next cycle edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0.
- Counting, P=8, par_en=0:
  - stimulus: en held high for 80 cycles.
  - required: edge_cnt cycles 0..7; bit_cnt runs 0..9 and returns to 0 exactly at cycle 80.
  - stimulus, par_en=1: 88 cycles.
  - required: bit_cnt reaches 10 and wraps to 0 at cycle 88.
- Majority vote, P=16:
  - stimulus: rx_in=0 for edge_cnt 6 and 8, rx_in=1 at edge_cnt 7.
  - required: sampled_bit=0 and sample_valid=1 when edge_cnt=9.
  - stimulus: a single-cycle 0 glitch at edge_cnt 7 only.
  - required: sampled_bit=1.
- Frame 0xA5, 8N1, P=8:
  - stimulus: drive the frame with data_sample_en=1.
  - required: the sample_valid pulses at edge_cnt=5 give sampled_bit = 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
- Abort:
  - stimulus: drop edge_bit_counter_en at bit_cnt=1, edge_cnt=3.
  - required: counters are 0 next cycle; no sample_valid pulse occurs until re-enabled.
- UART_RX_SYNC_EN defined, P=8:
  - stimulus: rx_in changes 2 cycles before the window.
  - required: the voted value reflects the pre-change level; sample_valid timing is unchanged (edge_cnt=5).
